// File: rtl/cordic_out_pkg.sv
// Shared definitions for the CORDIC output stage.
//   SEL_*          bit positions inside the one-hot function select
//   K_VAL_DEFAULT  CORDIC gain compensation 0.60725 * 2^16
//   state_e        control FSM states
//   fn_e           decoded function captured at accept
package cordic_out_pkg;

  localparam int SEL_SIN = 0;
  localparam int SEL_COS = 1;
  localparam int SEL_TAN = 2;
  localparam int SEL_ANG = 3;

  localparam int unsigned K_VAL_DEFAULT = 39797;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    OUT
  } state_e;

  typedef enum logic [2:0] {
    FN_SIN,
    FN_COS,
    FN_TAN,
    FN_ANG,
    FN_NONE
  } fn_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk, rst   clock and synchronous active-high reset (control only)
//   start      load dividend/divisor and begin WIDTH iterations
//   dividend   unsigned dividend
//   divisor    unsigned divisor (zero gives an undefined quotient)
//   done       high during the cycle whose edge writes the last quotient bit
//   quotient   quotient, final one cycle after done
module seq_divider #(
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // Dividend bits are shifted out of r_q from the top while quotient bits
  // enter at the bottom, so r_q holds the quotient after WIDTH steps.
  always_comb begin
    w_shift = {r_rem, r_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_div};
    // The partial remainder stays below the divisor, so a set top bit of the
    // difference can only mean a borrow.
    w_ge    = !w_diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      r_rem <= '0;
      r_q   <= dividend;
      r_div <= divisor;
    end else if (r_cnt != '0) begin
      r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_q   <= {r_q[WIDTH-2:0], w_ge};
    end
  end

  assign done     = (r_cnt == CNT_W'(1));
  assign quotient = r_q;

endmodule

// File: rtl/cordic_output_stage.sv
// Post-processing stage behind the CORDIC core: gain-compensated sin/cos,
// tan by sequential division, or angle pass-through, one result per
// valid/ready transaction.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready only in IDLE and not in reset
//   select               one-hot function, lowest set bit wins
//   x, y, angle          raw CORDIC results (signed)
//   out_valid/out_ready  output handshake
//   out_data             signed result, held after consumption
//   out_ovf              tan saturated (overflow or x == 0)
//   out_err              select had no bit set
//   busy                 FSM not in IDLE
module cordic_output_stage
  import cordic_out_pkg::*;
#(
  parameter int          DATA_W = 24,
  parameter int          FRAC_W = 16,
  parameter int          K_W    = 16,
  parameter int unsigned K_VAL  = K_VAL_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               select,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [DATA_W-1:0] angle,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_ovf,
  output logic                     out_err,
  output logic                     busy
);

  localparam int ITERS = DATA_W + FRAC_W;
  localparam int P_W   = DATA_W + K_W + 1;

  localparam logic signed [DATA_W-1:0] MAX   = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic        [ITERS-1:0]  MAX_Q = ITERS'(MAX);
  localparam logic signed [K_W:0]      K_S   = (K_W+1)'(K_VAL);
  localparam logic signed [P_W-1:0]    RND   = P_W'(1) << (K_W - 1);

  // Magnitude at DATA_W+1 bits so the most negative input is representable.
  function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W:0] e;
    e = {v[DATA_W-1], v};
    return e[DATA_W] ? -e : e;
  endfunction

  // Round half up and drop the K_W fractional bits of the gain product.
  // K < 1, so the result always fits DATA_W bits.
  function automatic logic signed [DATA_W-1:0] round_scale(input logic signed [P_W-1:0] p);
    logic signed [P_W-1:0] s;
    s = p + RND;
    return DATA_W'(s >>> K_W);
  endfunction

  // Returns {ovf, data} for the tan path.
  function automatic logic [DATA_W:0] sat_tan(input logic             x_zero,
                                              input logic             x_neg,
                                              input logic             y_neg,
                                              input logic [ITERS-1:0] q);
    logic signed [DATA_W-1:0] mag;
    if (x_zero)
      return {1'b1, (y_neg ? -MAX : MAX)};
    if (q > MAX_Q)
      return {1'b1, ((x_neg ^ y_neg) ? -MAX : MAX)};
    mag = q[DATA_W-1:0];
    return {1'b0, ((x_neg ^ y_neg) ? -mag : mag)};
  endfunction

  state_e                    r_state;
  fn_e                       r_fn_p0;
  logic signed [DATA_W-1:0]  r_op_p0;
  logic                      r_x_neg_p0;
  logic                      r_y_neg_p0;
  logic                      r_x_zero_p0;
  logic signed [P_W-1:0]     r_prod_p1;

  fn_e                       w_fn;
  logic signed [DATA_W-1:0]  w_op;
  logic                      w_accept;
  logic [DATA_W:0]           w_abs_x;
  logic [DATA_W:0]           w_abs_y;
  logic [ITERS-1:0]          w_dividend;
  logic [ITERS-1:0]          w_divisor;
  logic                      w_div_start;
  logic                      w_div_done;
  logic [ITERS-1:0]          w_quot;
  logic [DATA_W:0]           w_tan_res;
  logic signed [P_W-1:0]     w_mul_a;
  logic signed [P_W-1:0]     w_mul_k;

  always_comb begin
    w_fn = FN_NONE;
    w_op = '0;
    if (select[SEL_SIN]) begin
      w_fn = FN_SIN;
      w_op = y;
    end else if (select[SEL_COS]) begin
      w_fn = FN_COS;
      w_op = x;
    end else if (select[SEL_TAN]) begin
      w_fn = FN_TAN;
    end else if (select[SEL_ANG]) begin
      w_fn = FN_ANG;
      w_op = angle;
    end
  end

  assign in_ready    = (r_state == IDLE) && !rst;
  assign busy        = (r_state != IDLE);
  assign w_accept    = in_valid && in_ready;

  assign w_abs_x     = abs_ext(x);
  assign w_abs_y     = abs_ext(y);
  assign w_dividend  = ITERS'(w_abs_y) << FRAC_W;
  assign w_divisor   = ITERS'(w_abs_x);
  assign w_div_start = w_accept && (w_fn == FN_TAN);

  seq_divider #(
    .WIDTH(ITERS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .done     (w_div_done),
    .quotient (w_quot)
  );

  assign w_mul_a   = P_W'(r_op_p0);
  assign w_mul_k   = P_W'(K_S);
  assign w_tan_res = sat_tan(r_x_zero_p0, r_x_neg_p0, r_y_neg_p0, w_quot);

  // ---- p0: operands captured at accept; later input changes are ignored
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fn_p0     <= w_fn;
      r_op_p0     <= w_op;
      r_x_neg_p0  <= x[DATA_W-1];
      r_y_neg_p0  <= y[DATA_W-1];
      r_x_zero_p0 <= (x == '0);
    end
  end

  // ---- p1: gain product, registered in MUL
  always_ff @(posedge clk) begin
    if (r_state == MUL)
      r_prod_p1 <= w_mul_a * w_mul_k;
  end

  // ---- control FSM; results are written in FIX and held through OUT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept)
            r_state <= (w_fn == FN_TAN) ? DIV : MUL;
        end
        MUL: r_state <= FIX;
        DIV: begin
          if (w_div_done)
            r_state <= FIX;
        end
        FIX: begin
          out_valid <= 1'b1;
          r_state   <= OUT;
          case (r_fn_p0)
            FN_SIN, FN_COS: begin
              out_data <= round_scale(r_prod_p1);
              out_ovf  <= 1'b0;
              out_err  <= 1'b0;
            end
            FN_TAN: begin
              {out_ovf, out_data} <= w_tan_res;
              out_err             <= 1'b0;
            end
            FN_ANG: begin
              out_data <= r_op_p0;
              out_ovf  <= 1'b0;
              out_err  <= 1'b0;
            end
            default: begin
              out_data <= '0;
              out_ovf  <= 1'b0;
              out_err  <= 1'b1;
            end
          endcase
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_output_stage.sv
// Self-checking bench for cordic_output_stage at DATA_W=24, FRAC_W=16.
module tb_cordic_output_stage;

  typedef struct {
    logic [23:0] data;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  select = 4'b0;
  logic [23:0] x = '0;
  logic [23:0] y = '0;
  logic [23:0] angle = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic        out_ovf;
  logic        out_err;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  cordic_output_stage #(
    .DATA_W(24),
    .FRAC_W(16),
    .K_W   (16),
    .K_VAL (39797)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .x         (x),
    .y         (y),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [23:0] d, input logic o, input logic e, input int l);
    exp_t r;
    r.data = d; r.ovf = o; r.err = e; r.lat = l;
    return r;
  endfunction

  function automatic exp_t scale_model(input logic signed [23:0] v);
    longint p;
    p = longint'(v) * 39797 + 32768;
    return mk(24'(p >>> 16), 1'b0, 1'b0, 2);
  endfunction

  function automatic exp_t tan_model(input logic signed [23:0] xv, input logic signed [23:0] yv);
    longint ax, ay, q;
    logic neg;
    ax  = (xv < 0) ? -longint'(xv) : longint'(xv);
    ay  = (yv < 0) ? -longint'(yv) : longint'(yv);
    neg = xv[23] ^ yv[23];
    if (xv == 0)
      return mk((yv >= 0) ? 24'h7FFFFF : 24'h800001, 1'b1, 1'b0, 41);
    q = (ay << 16) / ax;
    if (q > 64'h7FFFFF)
      return mk(neg ? 24'h800001 : 24'h7FFFFF, 1'b1, 1'b0, 41);
    return mk(neg ? 24'(-q) : 24'(q), 1'b0, 1'b0, 41);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one transaction and returns just after its accept edge.
  task automatic drive(input logic [3:0] sel, input logic [23:0] xv,
                       input logic [23:0] yv, input logic [23:0] av);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    select   = sel;
    x        = xv;
    y        = yv;
    angle    = av;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x        = 24'($urandom);
    y        = 24'($urandom);
    angle    = 24'($urandom);
    select   = 4'($urandom);
  endtask

  // Edges until out_valid is seen; -1 when the budget runs out.
  task automatic wait_out(output int lat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    lat = out_valid ? cyc : -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (out_data !== 24'h0) $display("FAIL rst_data: got %h want 000000", out_data); else n_pass++;
    n_checks++; if ({out_ovf, out_err} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {out_ovf, out_err}); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low: got %b want 0", in_ready); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready_high: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_sin_hold();
    exp_t e;
    int   lat;
    drive(4'b0001, 24'h000000, 24'h010000, 24'h0);
    sb.push_back(mk(24'h009B75, 1'b0, 1'b0, 2));
    wait_out(lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat) $display("FAIL sin_lat: got %0d want %0d", lat, e.lat); else n_pass++;
    n_checks++; if (out_data !== e.data) $display("FAIL sin_data: got %h want %h", out_data, e.data); else n_pass++;
    n_checks++; if ({out_ovf, out_err} !== {e.ovf, e.err}) $display("FAIL sin_flags: got %b want %b", {out_ovf, out_err}, {e.ovf, e.err}); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== e.data) $display("FAIL sin_hold: got %b/%h want 1/%h", out_valid, out_data, e.data); else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL out_in_ready: got %b want 0", in_ready); else n_pass++;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL sin_consume: got valid=%b busy=%b want 0/0", out_valid, busy); else n_pass++;
    n_checks++; if (out_data !== e.data) $display("FAIL sin_data_kept: got %h want %h", out_data, e.data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL sin_idle_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_scale();
    logic [3:0]  sel[6]  = '{4'b0010, 4'b0011, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    logic [23:0] xs[6];
    logic [23:0] ys[6];
    exp_t e;
    int   lat;
    xs[0] = 24'hFF0000; ys[0] = 24'h0;
    xs[1] = 24'hFF0000; ys[1] = 24'h010000;
    xs[2] = 24'h0;      ys[2] = 24'h800000;
    xs[3] = 24'h7FFFFF; ys[3] = 24'h0;
    xs[4] = 24'h0;      ys[4] = 24'($urandom);
    xs[5] = 24'($urandom); ys[5] = 24'h0;
    for (int i = 0; i < 6; i++) begin
      drive(sel[i], xs[i], ys[i], 24'h0);
      if (i == 0)      sb.push_back(mk(24'hFF648B, 1'b0, 1'b0, 2));
      else if (i == 1) sb.push_back(mk(24'h009B75, 1'b0, 1'b0, 2));
      else             sb.push_back(scale_model(sel[i][0] ? ys[i] : xs[i]));
      wait_out(lat);
      e = sb.pop_front();
      n_checks++; if (lat !== e.lat) $display("FAIL scale_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
      n_checks++; if (out_data !== e.data) $display("FAIL scale_data[%0d]: got %h want %h", i, out_data, e.data); else n_pass++;
      n_checks++; if ({out_ovf, out_err} !== {e.ovf, e.err}) $display("FAIL scale_flags[%0d]: got %b want %b", i, {out_ovf, out_err}, {e.ovf, e.err}); else n_pass++;
      consume();
    end
  endtask

  task automatic test_tan();
    logic [23:0] xs[7];
    logic [23:0] ys[7];
    exp_t e;
    int   lat;
    xs[0] = 24'h020000; ys[0] = 24'h010000;
    xs[1] = 24'h000001; ys[1] = 24'h7FFFFF;
    xs[2] = 24'h000000; ys[2] = 24'hFFFFFB;
    xs[3] = 24'h800000; ys[3] = 24'h400000;
    xs[4] = 24'h020000; ys[4] = 24'hFF0000;
    xs[5] = 24'h000000; ys[5] = 24'h000000;
    xs[6] = 24'($urandom_range(24'h7FFFFF, 24'h040000)); ys[6] = 24'($urandom);
    for (int i = 0; i < 7; i++) begin
      drive(4'b0100, xs[i], ys[i], 24'h0);
      if (i == 0)      sb.push_back(mk(24'h008000, 1'b0, 1'b0, 41));
      else if (i == 1) sb.push_back(mk(24'h7FFFFF, 1'b1, 1'b0, 41));
      else if (i == 2) sb.push_back(mk(24'h800001, 1'b1, 1'b0, 41));
      else if (i == 3) sb.push_back(mk(24'hFF8000, 1'b0, 1'b0, 41));
      else             sb.push_back(tan_model(xs[i], ys[i]));
      wait_out(lat);
      e = sb.pop_front();
      n_checks++; if (lat !== e.lat) $display("FAIL tan_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
      n_checks++; if (out_data !== e.data) $display("FAIL tan_data[%0d]: got %h want %h", i, out_data, e.data); else n_pass++;
      n_checks++; if ({out_ovf, out_err} !== {e.ovf, e.err}) $display("FAIL tan_flags[%0d]: got %b want %b", i, {out_ovf, out_err}, {e.ovf, e.err}); else n_pass++;
      consume();
    end
  endtask

  task automatic test_angle_none();
    exp_t e;
    int   lat;
    for (int i = 0; i < 2; i++) begin
      drive((i == 0) ? 4'b1000 : 4'b0000, 24'h0, 24'h0, 24'h123456);
      sb.push_back((i == 0) ? mk(24'h123456, 1'b0, 1'b0, 2) : mk(24'h000000, 1'b0, 1'b1, 2));
      wait_out(lat);
      e = sb.pop_front();
      n_checks++; if (lat !== e.lat) $display("FAIL ang_lat[%0d]: got %0d want %0d", i, lat, e.lat); else n_pass++;
      n_checks++; if (out_data !== e.data) $display("FAIL ang_data[%0d]: got %h want %h", i, out_data, e.data); else n_pass++;
      n_checks++; if ({out_ovf, out_err} !== {e.ovf, e.err}) $display("FAIL ang_flags[%0d]: got %b want %b", i, {out_ovf, out_err}, {e.ovf, e.err}); else n_pass++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    drive(4'b0100, 24'h020000, 24'h010000, 24'h0);
    sb.push_back(mk(24'h008000, 1'b0, 1'b0, 41));
    select   = 4'b0001;
    y        = 24'h010000;
    in_valid = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL b2b_busy: got busy=%b ready=%b want 1/0", busy, in_ready); else n_pass++;
    wait_out(lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat - 1) $display("FAIL b2b_tan_lat: got %0d want %0d", lat, e.lat - 1); else n_pass++;
    n_checks++; if (out_data !== e.data) $display("FAIL b2b_tan_data: got %h want %h", out_data, e.data); else n_pass++;
    consume();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    sb.push_back(mk(24'h009B75, 1'b0, 1'b0, 2));
    wait_out(lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat) $display("FAIL b2b_sin_lat: got %0d want %0d", lat, e.lat); else n_pass++;
    n_checks++; if (out_data !== e.data) $display("FAIL b2b_sin_data: got %h want %h", out_data, e.data); else n_pass++;
    consume();
  endtask

  task automatic test_reset_mid_div();
    exp_t e;
    int   lat;
    // Leave nonzero data and ovf held from a saturated tan.
    drive(4'b0100, 24'h000000, 24'h000005, 24'h0);
    wait_out(lat);
    consume();
    drive(4'b0100, 24'h020000, 24'h010000, 24'h0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst_state: got valid=%b busy=%b want 0/0", out_valid, busy); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_data !== 24'h0 || out_ovf !== 1'b0) $display("FAIL mid_rst_out: got %h/%b want 000000/0", out_data, out_ovf); else n_pass++;
    drive(4'b0001, 24'h0, 24'h010000, 24'h0);
    sb.push_back(mk(24'h009B75, 1'b0, 1'b0, 2));
    wait_out(lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat) $display("FAIL post_rst_lat: got %0d want %0d", lat, e.lat); else n_pass++;
    n_checks++; if (out_data !== e.data) $display("FAIL post_rst_data: got %h want %h", out_data, e.data); else n_pass++;
    consume();
    drive(4'b0100, 24'h010000, 24'h020000, 24'h0);
    sb.push_back(mk(24'h020000, 1'b0, 1'b0, 41));
    wait_out(lat);
    e = sb.pop_front();
    n_checks++; if (lat !== e.lat) $display("FAIL post_rst_tan_lat: got %0d want %0d", lat, e.lat); else n_pass++;
    n_checks++; if (out_data !== e.data) $display("FAIL post_rst_tan_data: got %h want %h", out_data, e.data); else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_sin_hold();
    test_scale();
    test_tan();
    test_angle_none();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
